// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART frame engine.
// States, parity-mode constants and the frame parity function.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Data is zero-extended to 9 bits, so unused upper bits never affect the XOR.
  function automatic logic parity_bit(input logic [8:0] data, input int mode);
    logic p;
    p = ^data;
    return (mode == PARITY_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_rx_engine.sv
// UART receiver: input register stage, start-bit validation and mid-bit sampling.
// Defining UART_RX_SYNC_EN inserts a 2-flop synchroniser ahead of edge detection.
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = PARITY_EVEN
) (
  input  logic              clk_sis,
  input  logic              rst,
  input  logic              rx,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_parity_err,
  output logic              rx_frame_err
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_W);
  localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_MAX  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_W - 1);

  logic rx_in;
  logic rx_s_q, rx_prev_q;

`ifdef UART_RX_SYNC_EN
  logic [1:0] rx_sync_q;
  always_ff @(posedge clk_sis) begin
    if (rst) rx_sync_q <= 2'b11;
    else     rx_sync_q <= {rx_sync_q[0], rx};
  end
  assign rx_in = rx_sync_q[1];
`else
  assign rx_in = rx;
`endif

  rx_state_e         state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [IW-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              perr_pend_q, perr_pend_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    perr_pend_d = perr_pend_q;
    valid_d     = 1'b0;
    data_d      = data_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    case (state_q)
      RX_IDLE: begin
        timer_d = '0;
        if (rx_prev_q && !rx_s_q) state_d = RX_START;
      end
      RX_START: begin
        if (timer_q == HALF_MAX) begin
          // A start bit that is high again at mid-bit was only a glitch.
          timer_d = '0;
          if (rx_s_q) begin
            state_d = RX_IDLE;
          end else begin
            state_d     = RX_DATA;
            bit_idx_d   = '0;
            perr_pend_d = 1'b0;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (timer_q == TIMER_MAX) begin
          timer_d = '0;
          shift_d = {rx_s_q, shift_q[DATA_W-1:1]};
          if (bit_idx_q == LAST_BIT) state_d = (PARITY_MODE != PARITY_NONE) ? RX_PARITY : RX_STOP;
          else                       bit_idx_d = bit_idx_q + 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RX_PARITY: begin
        if (timer_q == TIMER_MAX) begin
          timer_d     = '0;
          perr_pend_d = rx_s_q != parity_bit(9'(shift_q), PARITY_MODE);
          state_d     = RX_STOP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (timer_q == TIMER_MAX) begin
          timer_d = '0;
          state_d = RX_IDLE;
          valid_d = 1'b1;
          data_d  = shift_q;
          perr_d  = perr_pend_q;
          ferr_d  = !rx_s_q;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_sis) begin
    if (rst) begin
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= RX_IDLE;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      perr_pend_q <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      rx_s_q      <= rx_in;
      rx_prev_q   <= rx_s_q;
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      perr_pend_q <= perr_pend_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
    end
  end

  assign rx_valid      = valid_q;
  assign rx_data       = data_q;
  assign rx_parity_err = perr_q;
  assign rx_frame_err  = ferr_q;

endmodule

// File: rtl/uart_frame_core.sv
// Full-duplex UART with configurable width and parity; TX FSM inline, RX in uart_rx_engine.
// Optional macro UART_RX_SYNC_EN adds a 2-flop synchroniser on rx.
module uart_frame_core
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = PARITY_EVEN
) (
  input  logic              clk_sis,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx,
  input  logic              rx,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_parity_err,
  output logic              rx_frame_err
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_W);
  localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [IW-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              tx_q, tx_d;

  // tx_d is the level for the next bit period, so each bit starts on the edge that ends the previous one.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tx_d      = tx_q;
    if (state_q == TX_IDLE) begin
      tx_d    = 1'b1;
      timer_d = '0;
      if (tx_valid) begin
        shift_d  = tx_data;
        parity_d = parity_bit(9'(tx_data), PARITY_MODE);
        state_d  = TX_START;
        tx_d     = 1'b0;
      end
    end else if (timer_q != TIMER_MAX) begin
      timer_d = timer_q + 1'b1;
    end else begin
      timer_d = '0;
      case (state_q)
        TX_START: begin
          state_d   = TX_DATA;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[DATA_W-1:1]};
        end
        TX_DATA: begin
          if (bit_idx_q == LAST_BIT) begin
            if (PARITY_MODE != PARITY_NONE) begin
              state_d = TX_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = TX_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[DATA_W-1:1]};
          end
        end
        TX_PARITY: begin
          state_d = TX_STOP;
          tx_d    = 1'b1;
        end
        TX_STOP: begin
          state_d = TX_IDLE;
          tx_d    = 1'b1;
        end
        default: begin
          state_d = TX_IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sis) begin
    if (rst) begin
      state_q   <= TX_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
    end
  end

  assign tx_ready = (state_q == TX_IDLE);
  assign tx       = tx_q;

  uart_rx_engine #(
    .DATA_W       (DATA_W),
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .PARITY_MODE  (PARITY_MODE)
  ) u_rx (
    .clk_sis       (clk_sis),
    .rst           (rst),
    .rx            (rx),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err)
  );

endmodule

// File: doc/uart_frame_core.md
# uart_frame_core

Parametrised full-duplex UART engine for the UART link in this design. It is the successor to the fixed 8-bit UART pair. Each frame carries a configurable data width and parity mode, and bit timing is derived from a single system clock. Parallel data enters and leaves through valid/ready-style strobes. The serial side connects `tx` to the peer's `rx`, cross-wired as between UART1 and UART2.

## Interface
- `DATA_W`, default 8: data bits per frame. Legal range 5..9.
- `CLKS_PER_BIT`, default 16: `clk_sis` cycles per bit. Must be even and ≥ 4.
- `PARITY_MODE`, default 1: 0 = none, 1 = even, 2 = odd.
- One clock; reset is synchronous and active-high.
- `clk_sis` in 1: system clock. Every register is clocked on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `tx_valid` in 1: a transmit request is present.
- `tx_data` in DATA_W: word to transmit.
- `tx_ready` out 1: the transmitter is idle and can accept a word.
- `tx` out 1: serial output. Idles high.
- `rx` in 1: serial input from the peer.
- `rx_valid` out 1: one-cycle pulse when a received frame completes.
- `rx_data` out DATA_W: last received word.
- `rx_parity_err` out 1: parity mismatch flag for the last frame. Always 0 when `PARITY_MODE` = 0.
- `rx_frame_err` out 1: the stop bit of the last frame was sampled low.

## Operation
- **Frame format:** start bit (0), then DATA_W data bits LSB first, then a parity bit if `PARITY_MODE` ≠ 0, then one stop bit (1).
- **Frame length:** NB = 2 + DATA_W + (PARITY_MODE ≠ 0) bits.
- **Parity:** even mode sends XOR of the data bits; odd mode sends its inverse.
- **TX FSM states:** IDLE → START → DATA → PARITY (skipped when `PARITY_MODE` = 0) → STOP → IDLE.
- **TX handshake:**
  - A word is accepted on any cycle with `tx_valid` && `tx_ready`; `tx_data` is captured into a shift register on that cycle.
  - `tx_ready` is 1 only in IDLE. `tx_valid` is ignored while busy, with no queuing.
- **RX FSM states:** IDLE → START → DATA → PARITY (optional) → STOP → IDLE.
- **RX start detection:**
  - A high-to-low transition on the (synchronised) `rx` moves the FSM to START.
  - `rx` is sampled at mid-bit, CLKS_PER_BIT/2 cycles after the edge.
  - If the sample is high, the start is treated as a glitch: return to IDLE with no `rx_valid`.
- **RX sampling:** subsequent bits are sampled every CLKS_PER_BIT cycles, at mid-bit.
- **RX completion:** after the stop-bit sample, the block updates `rx_data`, `rx_parity_err` and `rx_frame_err` and pulses `rx_valid`.
  - Data is delivered even when an error flag is set.
  - The outputs hold until the next completed frame.
- **RX re-arm:** RX returns to IDLE right after the stop-bit sample, so a start edge can be detected during the second half of the stop bit.
- **TX/RX independence:** TX and RX run fully independently and may be active in the same cycle.

## Timing
- **Reset values:** `tx`=1, `tx_ready`=1, `rx_valid`=0, `rx_data`=0, `rx_parity_err`=0, `rx_frame_err`=0. Both FSMs go to IDLE and all counters to 0.
- **Reset during a frame:** the frame is aborted. On the next edge `tx` is 1 and `tx_ready` is 1. A partially received RX frame is discarded with no `rx_valid`.
- **TX timing:**
  - After an accept at cycle n, `tx_ready` is 0 from cycle n+1.
  - `tx` goes 0 (start bit) at cycle n+1.
  - Each bit is held for exactly CLKS_PER_BIT cycles.
  - The stop bit ends at cycle n+NB·CLKS_PER_BIT, and `tx_ready` is 1 in the next cycle.
  - Back-to-back frames: `tx_valid` held high gives contiguous frames with no idle gap beyond one cycle.
- **RX timing:** `rx_valid` pulses 1 cycle after the stop-bit mid-sample. That is (NB−1)·CLKS_PER_BIT + CLKS_PER_BIT/2 + 1 cycles after the falling edge is seen at the FSM.
- **Counters:** the bit timer is $clog2(CLKS_PER_BIT) bits wide and wraps at CLKS_PER_BIT−1. The bit index is $clog2(DATA_W) bits wide and is compared against DATA_W−1.

## Configuration
- **Macro:** `UART_RX_SYNC_EN`.
- **Defined:** `rx` passes through a 2-flop synchroniser before edge detection, adding 2 cycles to RX latency.
- **Undefined:** `rx` is used after a single register stage only, for an already-synchronous source or loopback benches.

## Structure
- **Package `uart_pkg`:**
  - TX and RX state enums (IDLE, START, DATA, PARITY, STOP).
  - PARITY_NONE/EVEN/ODD constants.
  - A parity function taking the data and the mode.
- **Sub-module `uart_rx_engine`:** holds the RX FSM, synchroniser and sampling.
- **Top level:** the TX FSM stays inline in `uart_frame_core`.

## Test plan
Defaults are used throughout: DATA_W=8, CLKS_PER_BIT=16, even parity, `tx` looped to `rx`.
- **TX 0xA5:** accept at cycle 0 → `tx` carries 0,1,0,1,0,0,1,0,1,0(parity),1, each bit 16 cycles. `tx_ready` is back at 1 at cycle 177.
- **Loopback 0x3C:** `rx_valid` pulses once with `rx_data`=0x3C and both error flags 0.
- **Parity error:** drive `rx` with 0x01 and parity bit 0 → `rx_valid` with `rx_data`=0x01 and `rx_parity_err`=1.
- **Frame error:** drive `rx` with 0x55 and stop bit 0 → `rx_frame_err`=1, `rx_data`=0x55.
- **Glitch rejection:** `rx` low for 4 cycles, then high → no `rx_valid`, RX back in IDLE. A valid 0x81 frame sent next is received correctly.
- **Reset mid-frame:** `rst` asserted during TX bit 3 → `tx`=1 and `tx_ready`=1 on the next edge, and no `rx_valid` follows.
